// File: rtl/alu_seq.sv
// Sequential ALU with {C,Z} status output and a write strobe for the status-word register.
// Optional shift-add multiply for op 3'b111 is compiled in when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [1:0]       flags_o,
    output logic             flags_wen_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        ST_MUL  = 2'd2,
`endif
        ST_EXEC = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             wen_q, wen_d;
    logic             accept_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic [WIDTH:0]   sum_s, diff_s;

    assign accept_s = (state_q == ST_IDLE) && start_i;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               last_s;

    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Multiplier working registers: multiplicand shifts up, multiplier shifts down
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else if (accept_s) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= {CW{1'b0}};
        end else if (state_q == ST_MUL) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end else begin
            acc_q    <= acc_q;
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
            cnt_q    <= cnt_q;
        end
    end
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_i == 3'b111) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
`else
                    state_d = ST_EXEC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance; later input changes are ignored
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q <= 3'b000;
            a_q  <= {WIDTH{1'b0}};
            b_q  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
        end else begin
            op_q <= op_q;
            a_q  <= a_q;
            b_q  <= b_q;
        end
    end

    // Single-cycle ALU: sum/difference carry an extra bit for C
    always_comb begin
        sum_s     = {1'b0, a_q} + {1'b0, b_q};
        diff_s    = {1'b0, a_q} - {1'b0, b_q};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        case (op_q)
            3'b000: begin alu_res_s = sum_s[WIDTH-1:0];  alu_c_s = sum_s[WIDTH];  end
            3'b001: begin alu_res_s = diff_s[WIDTH-1:0]; alu_c_s = diff_s[WIDTH]; end
            3'b010: begin alu_res_s = a_q & b_q;         alu_c_s = 1'b0;          end
            3'b011: begin alu_res_s = a_q | b_q;         alu_c_s = 1'b0;          end
            3'b100: begin alu_res_s = a_q ^ b_q;         alu_c_s = 1'b0;          end
            3'b101: begin alu_res_s = {a_q[WIDTH-2:0], 1'b0}; alu_c_s = a_q[WIDTH-1]; end
            3'b110: begin alu_res_s = {1'b0, a_q[WIDTH-1:1]}; alu_c_s = a_q[0];       end
            default: begin alu_res_s = {WIDTH{1'b0}};    alu_c_s = 1'b0;          end
        endcase
    end

    // Output next-values: results and strobes only change at op completion
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        wen_d    = 1'b0;
        case (state_q)
            ST_EXEC: begin
                result_d = alu_res_s;
                done_d   = 1'b1;
                if (op_q == 3'b111) begin
                    flags_d = flags_q;
                    wen_d   = 1'b0;
                end else begin
                    flags_d = {alu_c_s, (alu_res_s == {WIDTH{1'b0}})};
                    wen_d   = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (last_s) begin
                    result_d = acc_d[WIDTH-1:0];
                    flags_d  = {(acc_d[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}),
                                (acc_d[WIDTH-1:0] == {WIDTH{1'b0}})};
                    done_d   = 1'b1;
                    wen_d    = 1'b1;
                end else begin
                    result_d = result_q;
                    flags_d  = flags_q;
                end
            end
`endif
            default: begin
                result_d = result_q;
                flags_d  = flags_q;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 2'b00;
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            wen_q    <= wen_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign flags_wen_o = wen_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results. Honours ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk_i, rst_i, start_i;
    logic [2:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, flags_wen_o;
    logic [W-1:0] result_o;
    logic [1:0]   flags_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .flags_o(flags_o), .flags_wen_o(flags_wen_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic
    function automatic logic [7:0] gold_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            3'd0: return 8'(ua + ub);
            3'd1: return 8'(ua - ub);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return 8'(ua * 2);
            3'd6: return 8'(ua / 2);
`ifdef ALU_SEQ_MUL_EN
            default: return 8'(ua * ub);
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    function automatic logic gold_c(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            3'd0: return (ua + ub) > 255;
            3'd1: return ua < ub;
            3'd5: return ua >= 128;
            3'd6: return (ua % 2) == 1;
            3'd7: return (ua * ub) > 255;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int gold_lat(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
        if (op == 3'd7) return W;
`endif
        return 1;
    endfunction

    function automatic bit gold_wen(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
        return 1'b1;
`else
        return op != 3'd7;
`endif
    endfunction

    // Model: remaining busy edges and the outcome pending at completion
    int         m_rem;
    logic       m_done, m_wen, p_wen;
    logic [7:0] m_res, p_res;
    logic [1:0] m_flags, p_flags;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_rem <= 0; m_done <= 1'b0; m_wen <= 1'b0; m_res <= 8'h00; m_flags <= 2'b00;
            p_wen <= 1'b0; p_res <= 8'h00; p_flags <= 2'b00;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            m_done <= (m_rem == 1);
            m_wen  <= (m_rem == 1) && p_wen;
            if (m_rem == 1) begin
                m_res <= p_res;
                if (p_wen) m_flags <= p_flags;
            end
        end else begin
            m_done <= 1'b0;
            m_wen  <= 1'b0;
            if (start_i) begin
                m_rem   <= gold_lat(op_i);
                p_res   <= gold_res(op_i, a_i, b_i);
                p_flags <= {gold_c(op_i, a_i, b_i), gold_res(op_i, a_i, b_i) == 8'h00};
                p_wen   <= gold_wen(op_i);
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("busy", busy_o, m_rem > 0);
            check("done", done_o, m_done);
            check("flags_wen", flags_wen_o, m_wen);
            check("result", result_o, m_res);
            check("flags", flags_o, m_flags);
            if (done_o) n_done++;
        end
    end

    // Called at posedge+2; returns at posedge+2 after the completion cycle
    task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [1:0] exp_flags, input logic exp_wen,
                          input int exp_lat, input bit pulse);
        int edges;
        bit seen;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk_i); #2;
        start_i = pulse; op_i = 3'd0; a_i = 8'($urandom); b_i = 8'($urandom);
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
            end else begin
                @(posedge clk_i); #2;
                edges++;
                if (edges == 2) start_i = 1'b0;
            end
        end
        check({nm, "_seen"}, seen, 1'b1);
        check({nm, "_lat"}, edges, exp_lat);
        check({nm, "_res"}, result_o, exp_res);
        check({nm, "_flags"}, flags_o, exp_flags);
        check({nm, "_wen"}, flags_wen_o, exp_wen);
        start_i = 1'b0;
        @(posedge clk_i); #2;
    endtask

    int done_before;

    initial begin
        rst_i = 1'b1; start_i = 1'b1; op_i = 3'd0; a_i = 8'h01; b_i = 8'h01;
        check("model_add", gold_res(3'd0, 8'hF0, 8'h20), 8'h10);
        check("model_sub_c", gold_c(3'd1, 8'h03, 8'h05), 1'b1);
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_res", result_o, 8'h00);
        check("rst_flags", flags_o, 2'b00);
        check("rst_wen", flags_wen_o, 1'b0);
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_busy", busy_o, 1'b0);
        @(posedge clk_i); #2;

        run_op("add",  3'd0, 8'hF0, 8'h20, 8'h10, 2'b10, 1'b1, 1, 1'b0);
        run_op("sub0", 3'd1, 8'h05, 8'h05, 8'h00, 2'b01, 1'b1, 1, 1'b0);
        run_op("shr",  3'd6, 8'h01, 8'h00, 8'h00, 2'b11, 1'b1, 1, 1'b0);
        run_op("and",  3'd2, 8'hCC, 8'hAA, 8'h88, 2'b00, 1'b1, 1, 1'b0);
        run_op("or",   3'd3, 8'h0C, 8'hA0, 8'hAC, 2'b00, 1'b1, 1, 1'b0);
        run_op("xor",  3'd4, 8'h5A, 8'h5A, 8'h00, 2'b01, 1'b1, 1, 1'b0);
        run_op("shl",  3'd5, 8'h81, 8'h00, 8'h02, 2'b10, 1'b1, 1, 1'b0);
        run_op("subb", 3'd1, 8'h03, 8'h05, 8'hFE, 2'b10, 1'b1, 1, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul",   3'd7, 8'd12, 8'd10, 8'h78, 2'b00, 1'b1, W, 1'b1);
        run_op("mul16", 3'd7, 8'd16, 8'd16, 8'h00, 2'b11, 1'b1, W, 1'b0);
`else
        run_op("mul_off", 3'd7, 8'd12, 8'd10, 8'h00, 2'b10, 1'b0, 1, 1'b0);
`endif

        // Back-to-back with start held: three ops complete in six edges
        done_before = n_done;
        start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op_i = 3'(i); a_i = 8'h7F + 8'(i * 37); b_i = 8'h01 + 8'(i * 19);
            @(posedge clk_i); #2;
        end
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("b2b_dones", n_done - done_before, 3);

        // Reset in the fourth cycle of a multiply
        start_i = 1'b1; op_i = 3'd7; a_i = 8'd12; b_i = 8'd10;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_res", result_o, 8'h00);
        check("abort_flags", flags_o, 2'b00);
        check("abort_wen", flags_wen_o, 1'b0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        done_before = n_done;
        repeat (W + 2) @(posedge clk_i);
        #2;
        check("abort_no_done", n_done - done_before, 0);
        run_op("add11", 3'd0, 8'h01, 8'h01, 8'h02, 2'b00, 1'b1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
